// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto one registered
// write port and keeps a per-register busy scoreboard for RAW/WAW issue stalls.
// Optional macro WB_FIXED_PRIORITY_EN: fixed LSU-over-ALU priority instead of round-robin.
module regfile_wb_scheduler #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                issue_rs1_en,
    input  logic                issue_rs2_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_en,
    output logic                issue_stall,
    input  logic                alu_wb_valid,
    input  logic [ADDR_W-1:0]   alu_wb_rd,
    input  logic [DATA_W-1:0]   alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                lsu_wb_valid,
    input  logic [ADDR_W-1:0]   lsu_wb_rd,
    input  logic [DATA_W-1:0]   lsu_wb_data,
    output logic                lsu_wb_ready,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic                alu_gnt, lsu_gnt;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] pend;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;

`ifdef WB_FIXED_PRIORITY_EN
    always_comb begin
        lsu_gnt = !rst && lsu_wb_valid;
        alu_gnt = !rst && alu_wb_valid && !lsu_wb_valid;
    end
`else
    // last_lsu_q = 1 means the LSU won the most recent grant
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst) begin
            if (alu_wb_valid && lsu_wb_valid) begin
                alu_gnt = last_lsu_q;
                lsu_gnt = !last_lsu_q;
            end else begin
                alu_gnt = alu_wb_valid;
                lsu_gnt = lsu_wb_valid;
            end
        end
        last_lsu_d = last_lsu_q;
        if (lsu_gnt)      last_lsu_d = 1'b1;
        else if (alu_gnt) last_lsu_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) last_lsu_q <= 1'b1;
        else     last_lsu_q <= last_lsu_d;
    end
`endif

    assign alu_wb_ready = alu_gnt;
    assign lsu_wb_ready = lsu_gnt;

    always_comb begin
        sel_rd     = lsu_gnt ? lsu_wb_rd   : alu_wb_rd;
        sel_data   = lsu_gnt ? lsu_wb_data : alu_wb_data;
        rf_we_d    = (alu_gnt || lsu_gnt) && (sel_rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_gnt || lsu_gnt) begin
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end
    end

    // A register being written this cycle is forwarded by the RF, so it is not pending
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            pend[r] = busy_q[r] && !(rf_we_q && rf_waddr_q == ADDR_W'(r));
        pend[0] = 1'b0;
    end

    assign issue_stall = issue_valid &&
                         ((issue_rs1_en && pend[issue_rs1]) ||
                          (issue_rs2_en && pend[issue_rs2]) ||
                          (issue_rd_en  && pend[issue_rd]));

    // Set is applied after clear so a same-register collision leaves the new writer busy
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q)
            busy_d[rf_waddr_q] = 1'b0;
        if (issue_valid && !issue_stall && issue_rd_en && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler (either arbitration build).
module tb_regfile_wb_scheduler;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_rs1_en, issue_rs2_en, issue_rd_en;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          issue_stall;
    logic          alu_wb_valid, lsu_wb_valid, alu_wb_ready, lsu_wb_ready;
    logic [AW-1:0] alu_wb_rd, lsu_wb_rd;
    logic [DW-1:0] alu_wb_data, lsu_wb_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NR-1:0] busy_vec;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_en(issue_rs1_en), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_stall(issue_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
    );

    task automatic idle();
        issue_valid = 0; issue_rs1_en = 0; issue_rs2_en = 0; issue_rd_en = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_wb_valid = 0; lsu_wb_valid = 0;
        alu_wb_rd = 0; lsu_wb_rd = 0; alu_wb_data = 0; lsu_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; alu_wb_valid = 1; lsu_wb_valid = 1;
        alu_wb_rd = 1; lsu_wb_rd = 2;
        tick(); tick();
        vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
        vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reset_we got %b exp 0", rf_we); end
        vecs++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b00) begin errs++;
            $display("FAIL reset_ready got %b exp 00", {alu_wb_ready, lsu_wb_ready}); end
        rst = 0; #1;
`ifdef WB_FIXED_PRIORITY_EN
        vecs++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b01) begin errs++;
            $display("FAIL first_contention got %b exp 01", {alu_wb_ready, lsu_wb_ready}); end
`else
        vecs++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b10) begin errs++;
            $display("FAIL first_contention got %b exp 10", {alu_wb_ready, lsu_wb_ready}); end
`endif
        idle();
        tick();
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_alu;
`ifdef WB_FIXED_PRIORITY_EN
        exp_alu = 4'b0000;
`else
        exp_alu = 4'b0101;
`endif
        alu_wb_valid = 1; lsu_wb_valid = 1;
        alu_wb_rd = 10; lsu_wb_rd = 11;
        alu_wb_data = 32'hA0A0_0001; lsu_wb_data = 32'h5050_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++; if ({alu_wb_ready, lsu_wb_ready} !== {exp_alu[i], !exp_alu[i]}) begin errs++;
                $display("FAIL arb_grant%0d got %b exp %b", i, {alu_wb_ready, lsu_wb_ready},
                         {exp_alu[i], !exp_alu[i]}); end
            tick();
            vecs++; if (rf_we !== 1'b1 || rf_waddr !== (exp_alu[i] ? 5'd10 : 5'd11)) begin errs++;
                $display("FAIL arb_write%0d got we=%b addr=%0d exp addr=%0d", i, rf_we, rf_waddr,
                         exp_alu[i] ? 10 : 11); end
        end
        idle();
        tick();
        vecs++; if (busy_vec !== '0 || rf_we !== 1'b0) begin errs++;
            $display("FAIL arb_idle got busy=%h we=%b exp 0/0", busy_vec, rf_we); end
    endtask

    task automatic test_raw_release();
        issue_valid = 1; issue_rd_en = 1; issue_rd = 5;
        #1;
        vecs++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL raw_first_issue stall=%b exp 0", issue_stall); end
        tick();
        vecs++; if (busy_vec !== 32'h20) begin errs++; $display("FAIL raw_busy_set got %h exp 00000020", busy_vec); end
        issue_rd_en = 0; issue_rs1_en = 1; issue_rs1 = 5;
        #1;
        vecs++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL raw_stall got %b exp 1", issue_stall); end
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
        #1;
        vecs++; if (alu_wb_ready !== 1'b1 || issue_stall !== 1'b1) begin errs++;
            $display("FAIL raw_wb_accept ready=%b stall=%b exp 1/1", alu_wb_ready, issue_stall); end
        tick();
        alu_wb_valid = 0;
        #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errs++;
            $display("FAIL raw_rf_write got we=%b addr=%0d data=%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        vecs++; if (issue_stall !== 1'b0 || busy_vec[5] !== 1'b1) begin errs++;
            $display("FAIL raw_bypass stall=%b busy5=%b exp 0/1", issue_stall, busy_vec[5]); end
        tick();
        idle();
        vecs++; if (busy_vec !== '0 || rf_we !== 1'b0) begin errs++;
            $display("FAIL raw_busy_clear got busy=%h we=%b exp 0/0", busy_vec, rf_we); end
    endtask

    task automatic test_zero_reg();
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h123;
        tick();
        vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL zero_wb_we got %b exp 0", rf_we); end
        alu_wb_valid = 0;
        lsu_wb_valid = 1; lsu_wb_rd = 0;
        issue_valid = 1; issue_rd_en = 1; issue_rd = 0; issue_rs1_en = 1; issue_rs1 = 0;
        #1;
        vecs++; if (lsu_wb_ready !== 1'b1 || issue_stall !== 1'b0) begin errs++;
            $display("FAIL zero_issue ready=%b stall=%b exp 1/0", lsu_wb_ready, issue_stall); end
        tick();
        idle();
        vecs++; if (busy_vec !== '0 || rf_we !== 1'b0) begin errs++;
            $display("FAIL zero_busy got busy=%h we=%b exp 0/0", busy_vec, rf_we); end
    endtask

    task automatic test_set_clear();
        issue_valid = 1; issue_rd_en = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 32'h7777;
        tick();
        lsu_wb_valid = 0;
        issue_valid = 1; issue_rd = 7;
        #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || issue_stall !== 1'b0) begin errs++;
            $display("FAIL same_reg_setup we=%b addr=%0d stall=%b exp 1/7/0", rf_we, rf_waddr, issue_stall); end
        tick();
        issue_valid = 0;
        vecs++; if (busy_vec !== 32'h80) begin errs++; $display("FAIL same_reg_set_wins got %h exp 00000080", busy_vec); end
        alu_wb_valid = 1; alu_wb_rd = 7;
        tick();
        alu_wb_valid = 0;
        issue_valid = 1; issue_rd = 9;
        tick();
        vecs++; if (busy_vec !== 32'h200) begin errs++; $display("FAIL diff_reg_both got %h exp 00000200", busy_vec); end
        #1;
        vecs++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL waw_stall got %b exp 1", issue_stall); end
        idle();
    endtask

    task automatic test_reset_mid();
        alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h9999;
        issue_valid = 1; issue_rd_en = 1; issue_rd = 3;
        tick();
        idle();
        vecs++; if (rf_we !== 1'b1 || busy_vec !== 32'h208) begin errs++;
            $display("FAIL rstmid_setup we=%b busy=%h exp 1/00000208", rf_we, busy_vec); end
        rst = 1;
        tick();
        rst = 0;
        vecs++; if (busy_vec !== '0 || rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin errs++;
            $display("FAIL rstmid got busy=%h we=%b addr=%0d data=%h exp all 0", busy_vec, rf_we, rf_waddr, rf_wdata); end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_raw_release();
        test_zero_reg();
        test_set_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
